// File: rtl/lights_sequencer.sv
// Single-clock LED wind-indicator sequencer: synchronized switch inputs, clock-enable
// prescaler, and a mode FSM that applies new modes only at step boundaries.
module lights_sequencer #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CW       = $clog2(TICK_DIV) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw,
    input  logic       hold,
    input  logic       step,
    output logic [2:0] out,
    output logic       tick,
    output logic       mode_chg,
    output logic [1:0] mode_act
);

    typedef enum logic [3:0] {
        S_IDLE, S_C0, S_C1, S_R0, S_R1, S_R2, S_L0, S_L1, S_L2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [1:0]    r_sw_m, r_sw_s;
    logic          r_hold_m, r_hold_s;
    logic          r_step_m, r_step_s, r_step_q;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic [1:0]    r_mode_act;
    logic          r_mode_chg;
    logic [2:0]    r_out;

    logic          w_step_edge;
    logic          w_tick;
    logic [1:0]    w_req;
    state_t        w_state_nxt;
    logic [1:0]    w_mode_nxt;
    logic          w_chg_nxt;

    function automatic state_t first_state(input logic [1:0] mode);
        case (mode)
            2'b01:   return S_R0;
            2'b10:   return S_L0;
            default: return S_C0;
        endcase
    endfunction

    function automatic logic [2:0] decode_out(input state_t s);
        case (s)
            S_C0:    return 3'b101;
            S_C1:    return 3'b010;
            S_R0:    return 3'b100;
            S_R1:    return 3'b010;
            S_R2:    return 3'b001;
            S_L0:    return 3'b001;
            S_L1:    return 3'b010;
            S_L2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_m   <= 2'b00;
            r_sw_s   <= 2'b00;
            r_hold_m <= 1'b0;
            r_hold_s <= 1'b0;
            r_step_m <= 1'b0;
            r_step_s <= 1'b0;
            r_step_q <= 1'b0;
        end else begin
            r_sw_m   <= sw;
            r_sw_s   <= r_sw_m;
            r_hold_m <= hold;
            r_hold_s <= r_hold_m;
            r_step_m <= step;
            r_step_s <= r_step_m;
            r_step_q <= r_step_s;
        end
    end

    // The count is frozen, not cleared, while held so free-running resumes mid-period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!r_hold_s) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign w_step_edge = r_step_s & ~r_step_q;
    assign w_tick      = (!r_hold_s && (r_cnt == CNT_LAST)) || (r_hold_s && w_step_edge);
    assign w_req       = (r_sw_s == 2'b11) ? 2'b00 : r_sw_s;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode_act;
        w_chg_nxt   = 1'b0;
        if (w_tick) begin
            if (r_state == S_IDLE || w_req != r_mode_act) begin
                w_state_nxt = first_state(w_req);
                w_mode_nxt  = w_req;
                w_chg_nxt   = 1'b1;
            end else begin
                case (r_state)
                    S_C0:    w_state_nxt = S_C1;
                    S_C1:    w_state_nxt = S_C0;
                    S_R0:    w_state_nxt = S_R1;
                    S_R1:    w_state_nxt = S_R2;
                    S_R2:    w_state_nxt = S_R0;
                    S_L0:    w_state_nxt = S_L1;
                    S_L1:    w_state_nxt = S_L2;
                    S_L2:    w_state_nxt = S_L0;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // out decodes the next state so the LEDs change on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mode_act <= 2'b00;
            r_mode_chg <= 1'b0;
            r_out      <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_mode_act <= w_mode_nxt;
            r_mode_chg <= w_chg_nxt;
            r_out      <= decode_out(w_state_nxt);
        end
    end

    assign out      = r_out;
    assign tick     = w_tick;
    assign mode_chg = r_mode_chg;
    assign mode_act = r_mode_act;

endmodule

// File: tb/tb_lights_sequencer.sv
// Self-checking bench for lights_sequencer: directed scenarios plus randomized switch,
// hold and step activity, compared against a pattern-index reference model.
module tb_lights_sequencer;

    localparam int TD = 4;

    logic       clk;
    logic       reset;
    logic [1:0] sw;
    logic       hold;
    logic       step;
    logic [2:0] out;
    logic       tick;
    logic       mode_chg;
    logic [1:0] mode_act;

    int n_checks = 0;
    int n_fail   = 0;

    lights_sequencer #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .hold     (hold),
        .step     (step),
        .out      (out),
        .tick     (tick),
        .mode_chg (mode_chg),
        .mode_act (mode_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode plus index into that mode's pattern list (-1 = idle).
    logic [1:0] m_sw1, m_sw2;
    logic       m_hold1, m_hold2, m_step1, m_step2, m_stepq;
    int         m_cnt;
    logic [1:0] m_mode;
    int         m_phase;
    logic       m_chg;

    function automatic int pat_len(input logic [1:0] mode);
        return (mode == 2'b00) ? 2 : 3;
    endfunction

    function automatic logic [2:0] m_out();
        logic [2:0] calm [2];
        logic [2:0] rl   [3];
        logic [2:0] lr   [3];
        calm = '{3'b101, 3'b010};
        rl   = '{3'b100, 3'b010, 3'b001};
        lr   = '{3'b001, 3'b010, 3'b100};
        if (m_phase < 0) return 3'b000;
        case (m_mode)
            2'b01:   return rl[m_phase];
            2'b10:   return lr[m_phase];
            default: return calm[m_phase];
        endcase
    endfunction

    function automatic logic m_tick();
        return (!m_hold2 && m_cnt == TD - 1) || (m_hold2 && m_step2 && !m_stepq);
    endfunction

    task automatic model_reset();
        m_sw1 = 2'b00; m_sw2 = 2'b00;
        m_hold1 = 0; m_hold2 = 0;
        m_step1 = 0; m_step2 = 0; m_stepq = 0;
        m_cnt = 0; m_mode = 2'b00; m_phase = -1; m_chg = 0;
    endtask

    // Advances DUT and model by one clock; called at a negedge with inputs already set.
    task automatic run_cycle(output logic exp_tick, output logic obs_tick);
        logic [1:0] req;
        exp_tick = m_tick();
        obs_tick = tick;
        @(posedge clk);
        req = (m_sw2 == 2'b11) ? 2'b00 : m_sw2;
        m_chg = 0;
        if (exp_tick) begin
            if (m_phase < 0 || req != m_mode) begin
                m_mode = req; m_phase = 0; m_chg = 1;
            end else begin
                m_phase = (m_phase + 1) % pat_len(m_mode);
            end
        end
        if (!m_hold2) m_cnt = (m_cnt + 1) % TD;
        m_stepq = m_step2; m_step2 = m_step1; m_step1 = step;
        m_hold2 = m_hold1; m_hold1 = hold;
        m_sw2 = m_sw1; m_sw1 = sw;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] sw_val);
        @(negedge clk);
        reset = 1'b0;
        sw = sw_val; hold = 1'b0; step = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic et, ot;
        do_reset(2'b00);
        n_checks++;
        if ({out, tick, mode_chg, mode_act} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_values: got out=%b tick=%b chg=%b act=%b, expected all zero",
                     out, tick, mode_chg, mode_act);
        end
        for (int i = 0; i < 14; i++) begin
            run_cycle(et, ot);
            n_checks++;
            if (ot !== et) begin
                n_fail++;
                $display("FAIL calm_tick cyc %0d: got %b expected %b", i, ot, et);
            end
            n_checks++;
            if ({out, mode_chg, mode_act} !== {m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL calm_out cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         i, out, mode_chg, mode_act, m_out(), m_chg, m_mode);
            end
            if (i == 3) begin
                n_checks++;
                if ({out, mode_chg} !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL first_step_edge4: got out=%b chg=%b expected 101/1", out, mode_chg);
                end
            end
        end
    endtask

    task automatic test_right_to_left();
        logic et, ot;
        do_reset(2'b01);
        for (int i = 0; i < 18; i++) begin
            run_cycle(et, ot);
            n_checks++;
            if (ot !== et) begin
                n_fail++;
                $display("FAIL rl_tick cyc %0d: got %b expected %b", i, ot, et);
            end
            n_checks++;
            if ({out, mode_chg, mode_act} !== {m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL rl_out cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         i, out, mode_chg, mode_act, m_out(), m_chg, m_mode);
            end
        end
    endtask

    task automatic test_mode_change();
        logic et, ot;
        int   budget;
        do_reset(2'b01);
        budget = 0;
        while (!(out === 3'b010 && mode_act === 2'b01) && budget < 40) begin
            run_cycle(et, ot);
            budget++;
        end
        n_checks++;
        if (budget >= 40) begin
            n_fail++;
            $display("FAIL mc_reach_r1: out=%b never reached 010 in mode 01", out);
        end
        sw = 2'b10;
        budget = 0;
        while (mode_chg !== 1'b1 && budget < 10) begin
            run_cycle(et, ot);
            n_checks++;
            if ({out, mode_chg, mode_act} !== {m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL mc_out: got %b/%b/%b expected %b/%b/%b",
                         out, mode_chg, mode_act, m_out(), m_chg, m_mode);
            end
            budget++;
        end
        n_checks++;
        if ({out, mode_chg, mode_act} !== 6'b001_1_10) begin
            n_fail++;
            $display("FAIL mc_apply: got out=%b chg=%b act=%b expected 001/1/10",
                     out, mode_chg, mode_act);
        end
        for (int i = 0; i < 10; i++) begin
            run_cycle(et, ot);
            n_checks++;
            if ({tick, out, mode_chg, mode_act} !== {1'b0, 6'b0} &&
                {ot, out, mode_chg, mode_act} !== {et, m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL mc_follow cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                         i, ot, out, mode_chg, mode_act, et, m_out(), m_chg, m_mode);
            end
        end
    endtask

    task automatic test_reserved();
        logic et, ot;
        int   chg_seen;
        do_reset(2'b00);
        for (int i = 0; i < 6; i++) run_cycle(et, ot);
        sw = 2'b11;
        chg_seen = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(et, ot);
            if (mode_chg === 1'b1) chg_seen++;
            n_checks++;
            if ({ot, out, mode_chg, mode_act} !== {et, m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL rsv_out cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                         i, ot, out, mode_chg, mode_act, et, m_out(), m_chg, m_mode);
            end
        end
        n_checks++;
        if (chg_seen != 0) begin
            n_fail++;
            $display("FAIL rsv_no_chg: got %0d mode_chg pulses expected 0", chg_seen);
        end
    endtask

    task automatic test_hold_step();
        logic et, ot;
        int   ticks, tick_pos;
        do_reset(2'b10);
        for (int i = 0; i < 9; i++) run_cycle(et, ot);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle(et, ot);
        ticks = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick_pos = -1;
            for (int i = 0; i < 10; i++) begin
                if (i == 5) step = 1'b0;
                run_cycle(et, ot);
                if (ot === 1'b1) begin
                    ticks++;
                    if (tick_pos < 0) tick_pos = i;
                end
                n_checks++;
                if ({ot, out, mode_chg, mode_act} !== {et, m_out(), m_chg, m_mode}) begin
                    n_fail++;
                    $display("FAIL hs_step p%0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                             p, i, ot, out, mode_chg, mode_act, et, m_out(), m_chg, m_mode);
                end
            end
            n_checks++;
            if (tick_pos != 2) begin
                n_fail++;
                $display("FAIL hs_latency p%0d: tick at cycle %0d expected 2", p, tick_pos);
            end
        end
        n_checks++;
        if (ticks != 3) begin
            n_fail++;
            $display("FAIL hs_tick_count: got %0d expected 3", ticks);
        end
        hold = 1'b0;
        for (int i = 0; i < 14; i++) begin
            run_cycle(et, ot);
            n_checks++;
            if ({ot, out, mode_chg, mode_act} !== {et, m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL hs_resume cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                         i, ot, out, mode_chg, mode_act, et, m_out(), m_chg, m_mode);
            end
        end
    endtask

    task automatic test_async_reset();
        logic et, ot;
        int   budget;
        do_reset(2'b10);
        budget = 0;
        while (!(m_out() == 3'b001 && m_cnt == 2) && budget < 30) begin
            run_cycle(et, ot);
            budget++;
        end
        n_checks++;
        if (budget >= 30 || out !== 3'b001) begin
            n_fail++;
            $display("FAIL ar_reach: out=%b expected 001 at cnt 2", out);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out, mode_act, tick, mode_chg} !== 7'b0) begin
            n_fail++;
            $display("FAIL ar_immediate: got out=%b act=%b tick=%b chg=%b expected zeros",
                     out, mode_act, tick, mode_chg);
        end
        model_reset();
        sw = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            run_cycle(et, ot);
            n_checks++;
            if ({ot, out, mode_chg, mode_act} !== {et, m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL ar_restart cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                         i, ot, out, mode_chg, mode_act, et, m_out(), m_chg, m_mode);
            end
            if (i == 3) begin
                n_checks++;
                if (out !== 3'b101) begin
                    n_fail++;
                    $display("FAIL ar_restart_c0: got %b expected 101", out);
                end
            end
        end
    endtask

    task automatic test_random();
        logic et, ot;
        do_reset(2'($urandom_range(0, 3)));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) sw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) hold = ~hold;
            if ($urandom_range(0, 3) == 0) step = ~step;
            run_cycle(et, ot);
            n_checks++;
            if ({ot, out, mode_chg, mode_act} !== {et, m_out(), m_chg, m_mode}) begin
                n_fail++;
                $display("FAIL rnd cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                         i, ot, out, mode_chg, mode_act, et, m_out(), m_chg, m_mode);
            end
        end
        hold = 1'b0;
        step = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        sw    = 2'b00;
        hold  = 1'b0;
        step  = 1'b0;
        model_reset();
        test_reset();
        test_right_to_left();
        test_mode_change();
        test_reserved();
        test_hold_step();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
